// File: rtl/meas_count_latch.sv
// Counts clock cycles while CLK_EN is high and latches the count on each OUT_COMP rising edge.
// The latched value is offered on a valid/ready read port. Define MEAS_AVG_EN to output a 4-sample average.
module meas_count_latch #(
    parameter int unsigned       WIDTH     = 24,
    parameter logic [WIDTH-1:0]  SAT_VALUE = {WIDTH{1'b1}}
) (
    input  logic             clock,
    input  logic             RST,
    input  logic             CLK_EN,
    input  logic             RESET,
    input  logic             OUT_COMP,
    input  logic             RD_READY,
    output logic [WIDTH-1:0] DATA,
    output logic             DATA_VALID,
    output logic             SAT,
    output logic             OVERRUN
);

    logic [WIDTH-1:0] r_cnt;
    logic             r_comp;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_sat;
    logic             r_overrun;

    logic             w_at_sat;
    logic             w_lat;
    logic             w_load;
    logic [WIDTH-1:0] w_new_data;
    logic             w_new_sat;

    assign w_at_sat = (r_cnt == SAT_VALUE);
    assign w_lat    = OUT_COMP & ~r_comp;

    always_ff @(posedge clock) begin
        if (RST) begin
            r_cnt  <= '0;
            r_comp <= 1'b0;
        end else begin
            r_comp <= OUT_COMP;
            if (RESET) begin
                r_cnt <= '0;
            end else if (CLK_EN && !w_at_sat) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

`ifdef MEAS_AVG_EN
    logic [WIDTH-1:0] r_hist [4];
    logic [3:0]       r_hist_sat;
    logic [WIDTH+1:0] r_sum;
    logic [2:0]       r_fill;
    logic [WIDTH+1:0] w_sum_next;

    // Window after this latch: the new sample plus the three newest stored ones.
    assign w_sum_next = r_sum + {2'b00, r_cnt} - {2'b00, r_hist[3]};
    assign w_new_data = w_sum_next[WIDTH+1:2];
    assign w_new_sat  = w_at_sat | r_hist_sat[0] | r_hist_sat[1] | r_hist_sat[2];
    assign w_load     = w_lat & (r_fill >= 3'd3);

    always_ff @(posedge clock) begin
        if (RST) begin
            for (int i = 0; i < 4; i++) begin
                r_hist[i] <= '0;
            end
            r_hist_sat <= '0;
            r_sum      <= '0;
            r_fill     <= '0;
        end else if (w_lat) begin
            r_hist[0]  <= r_cnt;
            r_hist[1]  <= r_hist[0];
            r_hist[2]  <= r_hist[1];
            r_hist[3]  <= r_hist[2];
            r_hist_sat <= {r_hist_sat[2:0], w_at_sat};
            r_sum      <= w_sum_next;
            if (r_fill != 3'd4) begin
                r_fill <= r_fill + 3'd1;
            end
        end
    end
`else
    assign w_new_data = r_cnt;
    assign w_new_sat  = w_at_sat;
    assign w_load     = w_lat;
`endif

    always_ff @(posedge clock) begin
        if (RST) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_sat     <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_load) begin
            r_data  <= w_new_data;
            r_sat   <= w_new_sat;
            r_valid <= 1'b1;
            // A load that coincides with a transfer leaves OVERRUN as it was.
            if (r_valid && !RD_READY) begin
                r_overrun <= 1'b1;
            end
        end else if (r_valid && RD_READY) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end
    end

    assign DATA       = r_data;
    assign DATA_VALID = r_valid;
    assign SAT        = r_sat;
    assign OVERRUN    = r_overrun;

endmodule

// File: tb/tb_meas_count_latch.sv
// Directed self-checking bench for meas_count_latch (raw build; averaging sequence when
// MEAS_AVG_EN is defined). A second instance with WIDTH=4 covers saturation.
module tb_meas_count_latch;

    logic        clock = 1'b0;
    logic        RST, CLK_EN, RESET, OUT_COMP, RD_READY;
    logic [23:0] DATA;
    logic        DATA_VALID, SAT, OVERRUN;

    logic        c4_en, c4_reset, c4_comp, c4_ready;
    logic [3:0]  d4_data;
    logic        d4_valid, d4_sat, d4_overrun;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    meas_count_latch #(.WIDTH(24)) dut (
        .clock(clock), .RST(RST), .CLK_EN(CLK_EN), .RESET(RESET), .OUT_COMP(OUT_COMP),
        .RD_READY(RD_READY), .DATA(DATA), .DATA_VALID(DATA_VALID), .SAT(SAT), .OVERRUN(OVERRUN)
    );

    meas_count_latch #(.WIDTH(4)) dut4 (
        .clock(clock), .RST(RST), .CLK_EN(c4_en), .RESET(c4_reset), .OUT_COMP(c4_comp),
        .RD_READY(c4_ready), .DATA(d4_data), .DATA_VALID(d4_valid), .SAT(d4_sat),
        .OVERRUN(d4_overrun)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic count(input int n);
        CLK_EN = 1'b1;
        repeat (n) step();
        CLK_EN = 1'b0;
    endtask

    task automatic pulse();
        OUT_COMP = 1'b1;
        step();
        OUT_COMP = 1'b0;
    endtask

    task automatic clear_cnt();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
    endtask

    task automatic pulse4();
        c4_comp = 1'b1;
        step();
        c4_comp = 1'b0;
    endtask

    initial begin
        RST = 1'b1; CLK_EN = 1'b0; RESET = 1'b0; OUT_COMP = 1'b0; RD_READY = 1'b0;
        c4_en = 1'b0; c4_reset = 1'b0; c4_comp = 1'b0; c4_ready = 1'b0;
        step();
        step();
        chk("rst_data", 32'(DATA), 32'd0);
        chk("rst_valid", 32'(DATA_VALID), 32'd0);
        chk("rst_sat", 32'(SAT), 32'd0);
        chk("rst_overrun", 32'(OVERRUN), 32'd0);
        RST = 1'b0;

`ifdef MEAS_AVG_EN
        // Running average over the last four latches
        clear_cnt(); count(10); pulse();
        chk("avg1_valid", 32'(DATA_VALID), 32'd0);
        clear_cnt(); count(20); pulse();
        chk("avg2_valid", 32'(DATA_VALID), 32'd0);
        clear_cnt(); count(30); pulse();
        chk("avg3_valid", 32'(DATA_VALID), 32'd0);
        clear_cnt(); count(41); pulse();
        chk("avg4_valid", 32'(DATA_VALID), 32'd1);
        chk("avg4_data", 32'(DATA), 32'd25);
        chk("avg4_sat", 32'(SAT), 32'd0);
        clear_cnt(); count(50); pulse();
        chk("avg5_data", 32'(DATA), 32'd35);
        chk("avg5_valid", 32'(DATA_VALID), 32'd1);
        chk("avg5_overrun", 32'(OVERRUN), 32'd1);
`else
        // Basic count and latch
        count(100);
        pulse();
        chk("t1_data", 32'(DATA), 32'd100);
        chk("t1_valid", 32'(DATA_VALID), 32'd1);
        chk("t1_sat", 32'(SAT), 32'd0);

        // Overwrite of an unread sample, then read
        RD_READY = 1'b1; step(); RD_READY = 1'b0;
        chk("t2_read0_valid", 32'(DATA_VALID), 32'd0);
        chk("t2_read0_data", 32'(DATA), 32'd100);
        clear_cnt(); count(50); pulse();
        chk("t2_first_data", 32'(DATA), 32'd50);
        chk("t2_first_overrun", 32'(OVERRUN), 32'd0);
        count(30); pulse();
        chk("t2_second_data", 32'(DATA), 32'd80);
        chk("t2_second_overrun", 32'(OVERRUN), 32'd1);
        RD_READY = 1'b1; step(); RD_READY = 1'b0;
        chk("t2_read_valid", 32'(DATA_VALID), 32'd0);
        chk("t2_read_overrun", 32'(OVERRUN), 32'd0);
        chk("t2_read_data", 32'(DATA), 32'd80);

        // Latch coinciding with a transfer
        clear_cnt(); count(7); pulse();
        chk("t3_pre_data", 32'(DATA), 32'd7);
        count(5);
        OUT_COMP = 1'b1; RD_READY = 1'b1; step(); OUT_COMP = 1'b0;
        chk("t3_data", 32'(DATA), 32'd12);
        chk("t3_valid", 32'(DATA_VALID), 32'd1);
        chk("t3_overrun", 32'(OVERRUN), 32'd0);
        step(); RD_READY = 1'b0;
        chk("t3_drain_valid", 32'(DATA_VALID), 32'd0);

        // Saturation on the 4-bit instance, then RESET and RESET+latch
        c4_reset = 1'b1; step(); c4_reset = 1'b0;
        c4_en = 1'b1; repeat (20) step(); c4_en = 1'b0;
        pulse4();
        chk("t4_sat_data", 32'(d4_data), 32'd15);
        chk("t4_sat_flag", 32'(d4_sat), 32'd1);
        c4_reset = 1'b1; step(); c4_reset = 1'b0;
        pulse4();
        chk("t4_clr_data", 32'(d4_data), 32'd0);
        chk("t4_clr_sat", 32'(d4_sat), 32'd0);
        chk("t4_overrun", 32'(d4_overrun), 32'd1);
        c4_en = 1'b1; repeat (5) step(); c4_en = 1'b0;
        c4_reset = 1'b1; c4_comp = 1'b1; step(); c4_reset = 1'b0; c4_comp = 1'b0;
        chk("t4_reset_latch_data", 32'(d4_data), 32'd5);
        step();
        pulse4();
        chk("t4_after_reset_data", 32'(d4_data), 32'd0);

        // OUT_COMP held high gives a single latch of the pre-increment count
        clear_cnt(); count(3);
        CLK_EN = 1'b1; OUT_COMP = 1'b1;
        repeat (10) step();
        CLK_EN = 1'b0; OUT_COMP = 1'b0;
        chk("t5_hold_data", 32'(DATA), 32'd3);
        chk("t5_hold_valid", 32'(DATA_VALID), 32'd1);
        chk("t5_hold_overrun", 32'(OVERRUN), 32'd0);

        // RST mid-count discards the count and the pending sample
        clear_cnt(); count(37);
        RST = 1'b1; step(); RST = 1'b0;
        chk("t5_rst_valid", 32'(DATA_VALID), 32'd0);
        chk("t5_rst_data", 32'(DATA), 32'd0);
        repeat (3) step();
        chk("t5_rst_quiet_valid", 32'(DATA_VALID), 32'd0);
        pulse();
        chk("t5_after_rst_data", 32'(DATA), 32'd0);
        chk("t5_after_rst_valid", 32'(DATA_VALID), 32'd1);

        // Raw samples in the non-averaging build
        RD_READY = 1'b1;
        clear_cnt(); count(41); pulse();
        chk("t6_raw41", 32'(DATA), 32'd41);
        clear_cnt(); count(50); pulse();
        chk("t6_raw50", 32'(DATA), 32'd50);
        RD_READY = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
